// File: rtl/drive_cmd_arbiter.sv
// Drive-direction arbiter: picks the manual or autonomous command stream and issues one
// registered one-hot direction, with mode-switch stop dwell, command watchdog and e-stop.
module drive_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned SWITCH_HOLD    = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       manual_valid,
  input  logic [7:0] manual_cmd,
  input  logic       auto_valid,
  input  logic [7:0] auto_cmd,
  input  logic       mode_req,
  input  logic       estop,
  output logic [8:0] dir,
  output logic       active_mode,
  output logic       switching,
  output logic       timeout,
  output logic       bad_cmd
);
  // state     | meaning
  // SWITCH    | forced stop dwell before handing control to the mode_req source
  // RUN_MAN   | manual stream in control
  // RUN_AUTO  | autonomous stream in control
  // ESTOP     | emergency stop held while estop is high
  typedef enum logic [1:0] {ST_SWITCH, ST_RUN_MAN, ST_RUN_AUTO, ST_ESTOP} state_e;

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned HD_W = $clog2(SWITCH_HOLD + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HD_W-1:0] HD_LAST = HD_W'(SWITCH_HOLD - 1);
  localparam logic [8:0] DIR_STOP = 9'h100;

  state_e          state_q, state_d;
  logic [HD_W-1:0] hold_q, hold_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            target_q, target_d;
  logic [8:0]      dir_q, dir_d;
  logic            mode_q, mode_d;
  logic            switching_q, switching_d;
  logic            timeout_q, timeout_d;
  logic            bad_q, bad_d;

  logic       src_valid;
  logic [7:0] src_cmd;
  logic       dec_ok;
  logic [8:0] dec_dir;

  always_comb begin
    src_valid = mode_q ? auto_valid : manual_valid;
    src_cmd   = mode_q ? auto_cmd : manual_cmd;
    dec_ok    = (src_cmd[7:4] == 4'h0);
    dec_dir   = DIR_STOP;
    case (src_cmd[3:0])
      4'b0001: dec_dir = 9'h001;
      4'b0010: dec_dir = 9'h002;
      4'b0100: dec_dir = 9'h004;
      4'b1000: dec_dir = 9'h008;
      4'b0011: dec_dir = 9'h010;
      4'b1001: dec_dir = 9'h020;
      4'b0110: dec_dir = 9'h040;
      4'b1100: dec_dir = 9'h080;
      4'b0000, 4'b0101, 4'b1010: dec_dir = DIR_STOP;
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    wdog_d    = wdog_q;
    target_d  = target_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    timeout_d = timeout_q;
    bad_d     = 1'b0;
    if (estop) begin
      state_d   = ST_ESTOP;
      dir_d     = DIR_STOP;
      timeout_d = 1'b0;
      wdog_d    = '0;
      hold_d    = '0;
    end else begin
      case (state_q)
        ST_ESTOP: begin
          state_d  = ST_SWITCH;
          hold_d   = '0;
          target_d = mode_req;
        end
        ST_SWITCH: begin
          dir_d = DIR_STOP;
          // any movement of mode_req during the dwell restarts it
          if (mode_req != target_q) begin
            target_d = mode_req;
            hold_d   = '0;
          end else if (hold_q == HD_LAST) begin
            state_d   = mode_req ? ST_RUN_AUTO : ST_RUN_MAN;
            mode_d    = mode_req;
            wdog_d    = '0;
            timeout_d = 1'b0;
            hold_d    = '0;
          end else begin
            hold_d = hold_q + HD_W'(1);
          end
        end
        default: begin
          if (mode_req != mode_q) begin
            state_d  = ST_SWITCH;
            dir_d    = DIR_STOP;
            hold_d   = '0;
            target_d = mode_req;
            wdog_d   = '0;
          end else if (src_valid) begin
            wdog_d = '0;
            if (dec_ok) begin
              dir_d     = dec_dir;
              timeout_d = 1'b0;
            end else begin
              bad_d = 1'b1;
            end
          end else if (wdog_q == WD_LAST) begin
            dir_d     = DIR_STOP;
            timeout_d = 1'b1;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
        end
      endcase
    end
    switching_d = (state_d == ST_SWITCH) || (state_d == ST_ESTOP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SWITCH;
      hold_q      <= '0;
      wdog_q      <= '0;
      target_q    <= 1'b0;
      dir_q       <= DIR_STOP;
      mode_q      <= 1'b0;
      switching_q <= 1'b1;
      timeout_q   <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      wdog_q      <= wdog_d;
      target_q    <= target_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
      switching_q <= switching_d;
      timeout_q   <= timeout_d;
      bad_q       <= bad_d;
    end
  end

  assign dir         = dir_q;
  assign active_mode = mode_q;
  assign switching   = switching_q;
  assign timeout     = timeout_q;
  assign bad_cmd     = bad_q;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Bench for drive_cmd_arbiter: timestamp-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_drive_cmd_arbiter;
  localparam int TMO  = 8;
  localparam int HOLD = 4;
  localparam logic [8:0] STOP = 9'h100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       manual_valid = 1'b0;
  logic [7:0] manual_cmd = 8'h00;
  logic       auto_valid = 1'b0;
  logic [7:0] auto_cmd = 8'h00;
  logic       mode_req = 1'b0;
  logic       estop = 1'b0;
  logic [8:0] dir;
  logic       active_mode, switching, timeout, bad_cmd;

  int n_pass = 0;
  int n_total = 0;

  drive_cmd_arbiter #(.TIMEOUT_CYCLES(TMO), .SWITCH_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset),
    .manual_valid(manual_valid), .manual_cmd(manual_cmd),
    .auto_valid(auto_valid), .auto_cmd(auto_cmd),
    .mode_req(mode_req), .estop(estop),
    .dir(dir), .active_mode(active_mode), .switching(switching),
    .timeout(timeout), .bad_cmd(bad_cmd)
  );

  always #5 clk = ~clk;

  // command byte -> one-hot {stop,sd,as,wd,wa,d,s,a,w}
  localparam logic [7:0] TAB_CMD [11] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h03, 8'h09,
                                          8'h06, 8'h0C, 8'h00, 8'h05, 8'h0A};
  localparam logic [8:0] TAB_DIR [11] = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h020,
                                          9'h040, 9'h080, 9'h100, 9'h100, 9'h100};

  function automatic bit lookup(input logic [7:0] c, output logic [8:0] d);
    lookup = 1'b0;
    d = STOP;
    for (int i = 0; i < 11; i++)
      if (TAB_CMD[i] == c) begin
        lookup = 1'b1;
        d = TAB_DIR[i];
      end
  endfunction

  // model: times are edge numbers; dwell ends HOLD edges after it began, watchdog
  // fires TMO edges after the last accepted command
  int         m_cyc, m_since, m_last;
  bit         m_sw, m_es, m_tgt, m_ctrl, m_tmo, m_bad;
  logic [8:0] m_dir;

  always @(posedge clk or posedge reset) begin : model
    int now;
    logic [8:0] d;
    bit ok;
    if (reset) begin
      m_cyc <= 0; m_since <= 0; m_last <= 0;
      m_sw <= 1'b1; m_es <= 1'b0; m_tgt <= 1'b0; m_ctrl <= 1'b0;
      m_dir <= STOP; m_tmo <= 1'b0; m_bad <= 1'b0;
    end else begin
      now = m_cyc + 1;
      m_cyc <= now;
      m_bad <= 1'b0;
      if (estop) begin
        m_es <= 1'b1; m_dir <= STOP; m_tmo <= 1'b0;
      end else if (m_es) begin
        m_es <= 1'b0; m_sw <= 1'b1; m_since <= now; m_tgt <= mode_req;
      end else if (m_sw) begin
        if (mode_req != m_tgt) begin
          m_tgt <= mode_req; m_since <= now;
        end else if (now - m_since >= HOLD) begin
          m_sw <= 1'b0; m_ctrl <= mode_req; m_last <= now; m_tmo <= 1'b0;
        end
      end else begin
        if (mode_req != m_ctrl) begin
          m_sw <= 1'b1; m_since <= now; m_tgt <= mode_req; m_dir <= STOP;
        end else if (m_ctrl ? auto_valid : manual_valid) begin
          m_last <= now;
          ok = lookup(m_ctrl ? auto_cmd : manual_cmd, d);
          if (ok) begin
            m_dir <= d; m_tmo <= 1'b0;
          end else begin
            m_bad <= 1'b1;
          end
        end else if (now - m_last >= TMO) begin
          m_dir <= STOP; m_tmo <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("m_dir", dir, m_dir);
    chk("m_switching", {8'h0, switching}, {8'h0, m_sw | m_es});
    chk("m_timeout", {8'h0, timeout}, {8'h0, m_tmo});
    chk("m_bad_cmd", {8'h0, bad_cmd}, {8'h0, m_bad});
    chk("onehot", {8'h0, $onehot(dir)}, 9'h001);
    if (!(m_sw | m_es)) chk("m_active_mode", {8'h0, active_mode}, {8'h0, m_ctrl});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic man(input logic [7:0] c);
    manual_valid = 1'b1; manual_cmd = c;
    tick();
    manual_valid = 1'b0;
  endtask

  task automatic aut(input logic [7:0] c);
    auto_valid = 1'b1; auto_cmd = c;
    tick();
    auto_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL time_limit: bench did not complete, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_dir", dir, STOP);
    chk("rst_switching", {8'h0, switching}, 9'h001);
    chk("rst_active_mode", {8'h0, active_mode}, 9'h000);
    chk("rst_timeout", {8'h0, timeout}, 9'h000);
    chk("rst_bad_cmd", {8'h0, bad_cmd}, 9'h000);
    #10 reset = 1'b0;

    // 1: four-cycle dwell, then manual wa
    repeat (3) tick();
    chk("t1_still_switching", {8'h0, switching}, 9'h001);
    tick();
    chk("t1_run_man", {8'h0, switching}, 9'h000);
    chk("t1_mode", {8'h0, active_mode}, 9'h000);
    man(8'h03);
    chk("t1_wa", dir, 9'h010);

    // 2: inactive source ignored
    manual_valid = 1'b1; manual_cmd = 8'h01; auto_valid = 1'b1; auto_cmd = 8'h04;
    tick();
    manual_valid = 1'b0; auto_valid = 1'b0;
    chk("t2_w", dir, 9'h001);
    aut(8'h04);
    chk("t2_auto_ignored", dir, 9'h001);

    // 3: invalid decodes, then explicit stop code
    man(8'h07);
    chk("t3_bad_07", {8'h0, bad_cmd}, 9'h001);
    chk("t3_dir_kept", dir, 9'h001);
    tick();
    chk("t3_bad_pulse_end", {8'h0, bad_cmd}, 9'h000);
    man(8'h11);
    chk("t3_bad_11", {8'h0, bad_cmd}, 9'h001);
    man(8'h05);
    chk("t3_stop_05", dir, STOP);

    // 4: watchdog
    man(8'h01);
    chk("t4_w", dir, 9'h001);
    repeat (7) tick();
    chk("t4_before_expiry", {timeout, dir[7:0]}, 9'h001);
    tick();
    chk("t4_expired_dir", dir, STOP);
    chk("t4_timeout", {8'h0, timeout}, 9'h001);
    man(8'h08);
    chk("t4_d", dir, 9'h008);
    chk("t4_timeout_clr", {8'h0, timeout}, 9'h000);

    // 5: mode change (with a dropped same-cycle valid) and dwell restart
    man(8'h01);
    mode_req = 1'b1;
    man(8'h08);
    chk("t5_stop", dir, STOP);
    chk("t5_switching", {8'h0, switching}, 9'h001);
    tick();
    mode_req = 1'b0;
    tick();
    mode_req = 1'b1;
    auto_valid = 1'b1; auto_cmd = 8'h01;
    tick();
    auto_valid = 1'b0;
    repeat (3) tick();
    chk("t5_hold_restarted", {8'h0, switching}, 9'h001);
    chk("t5_hold_dir", dir, STOP);
    tick();
    chk("t5_run_auto", {7'h0, switching, active_mode}, 9'h001);
    aut(8'h09);
    chk("t5_wd", dir, 9'h020);

    // 6: e-stop, dwell, reset mid-dwell
    aut(8'h0C);
    chk("t6_sd", dir, 9'h080);
    estop = 1'b1;
    tick();
    chk("t6_estop_dir", dir, STOP);
    chk("t6_estop_sw", {8'h0, switching}, 9'h001);
    repeat (2) tick();
    estop = 1'b0;
    repeat (4) tick();
    chk("t6_dwell", {8'h0, switching}, 9'h001);
    tick();
    chk("t6_back_auto", {7'h0, switching, active_mode}, 9'h001);
    chk("t6_dir_stop", dir, STOP);
    mode_req = 1'b0;
    repeat (3) tick();
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_dir", dir, STOP);
    chk("t6_rst_flags", {6'h0, active_mode, switching, timeout}, 9'h002);
    chk("t6_rst_bad", {8'h0, bad_cmd}, 9'h000);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) tick();
    man(8'h02);
    chk("t6_after_rst_a", dir, 9'h002);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
